fir_filter: RTL and testbench
=============================

FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 The block SHALL have parameter TAPS, default 16, meaning the number of filter taps (range 2..32).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the signed sample width.
REQ-003 The block SHALL have parameter COEF_W, default 16, meaning the signed Q1.(COEF_W-1) coefficient width.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port sample_valid_i, input, 1 bit: a one-cycle strobe marking a new ADC sample.
REQ-007 The block SHALL have port sample_i, input, DATA_W bits, signed: the ADC sample, valid only when sample_valid_i=1.
REQ-008 The block SHALL have port clear_i, input, 1 bit: synchronous flush of the delay line.
REQ-009 The block SHALL have port data_o, output, DATA_W bits, signed: the filtered sample, held until the next result, and fed to the DAC writer.
REQ-010 The block SHALL have port valid_o, output, 1 bit: a one-cycle pulse when data_o updates.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high while the state is not IDLE.
REQ-012 The block SHALL have port overrun_o, output, 1 bit: a sticky flag set by a sample arriving while busy.

Function
REQ-013 The block SHALL use a TAPS-entry circular delay line with write pointer wr_ptr, which wraps from TAPS-1 to 0.
REQ-014 The block SHALL implement four states: IDLE, MAC, ROUND and OUT.
REQ-015 In IDLE with sample_valid_i=1, the block SHALL write sample_i at wr_ptr, clear the accumulator, set tap index k=0 and go to MAC.
REQ-016 In MAC, each cycle the block SHALL add coef[k] * x[n-k] to the accumulator, where x[n-k] is read at (wr_ptr-k) mod TAPS.
REQ-017 After TAPS cycles in MAC, with k=TAPS-1 processed, the block SHALL go to ROUND.
REQ-018 The accumulator SHALL be DATA_W+COEF_W+clog2(TAPS) bits, signed, and SHALL never overflow internally.
REQ-019 In ROUND, the block SHALL add 2^(COEF_W-2), arithmetic-shift right by COEF_W-1, and saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-020 In OUT, the block SHALL register data_o, pulse valid_o for exactly one cycle, advance wr_ptr, and return to IDLE.
REQ-021 Latency SHALL be fixed: valid_o is high exactly TAPS+2 cycles after the sample_valid_i cycle, which is 18 cycles at default TAPS.
REQ-022 The block SHALL accept a new sample on the cycle after OUT, giving a sustained rate of 1 sample per TAPS+3 cycles.
REQ-023 When sample_valid_i=1 while busy_o=1, the sample SHALL be dropped, overrun_o SHALL be set, and the computation in progress SHALL be unaffected.
REQ-024 overrun_o SHALL clear only on reset or clear_i.
REQ-025 On clear_i=1, the block SHALL zero all delay-line entries, set wr_ptr=0, abort any computation, enter IDLE, clear overrun_o, and leave data_o unchanged.
REQ-026 clear_i SHALL take priority over a simultaneous sample_valid_i, and that sample SHALL be dropped without setting overrun_o.
REQ-027 Coefficients SHALL be constants; they are not runtime-loadable.

Reset
REQ-028 While reset_ni=0, the block SHALL hold state=IDLE, data_o=0, valid_o=0, busy_o=0, overrun_o=0, wr_ptr=0, accumulator=0 and all delay-line entries=0.
REQ-029 Reset assertion SHALL take effect asynchronously, including in the middle of MAC; no valid_o pulse SHALL follow from the aborted sample.
REQ-030 The first sample accepted after reset deassertion SHALL be filtered against an all-zero history.

Structure
REQ-031 The shared package fir_pkg SHALL hold the state enum typedef, the FIR_TAPS default, and the coefficient array constant FIR_COEF (16-tap symmetric low-pass, Q1.15, coefficient sum <= 32767).
REQ-032 The multiply-accumulate datapath SHALL be one sub-module, fir_mac, containing the multiplier, the accumulator register, and clear and enable inputs.

Verification
REQ-033 Impulse test: 32767 followed by zeros, each sample 50 cycles apart, SHALL produce data_o equal to FIR_COEF[k] rounded, for k=0..15, then 0.
REQ-034 DC test: a constant input of 32767 SHALL settle data_o to round(32767*sum(FIR_COEF)/32768) with no wrap; with a test coefficient set summing above 1.0, data_o SHALL saturate at 32767.
REQ-035 Latency and back-pressure test: sample_valid_i at cycle 0 SHALL give valid_o at cycle 18; a strobe at cycle 5 SHALL set overrun_o=1 and leave the cycle-18 result equal to the single-sample value.
REQ-036 Reset test: reset_ni dropped at cycle 8 of MAC SHALL force busy_o=0 and data_o=0 immediately, and no valid_o SHALL appear within 30 cycles after release.
REQ-037 Clear test: clear_i asserted simultaneously with sample_valid_i SHALL give no valid_o and overrun_o=0, and the next impulse SHALL reproduce REQ-033 exactly.
REQ-038 Wrap test: 40 consecutive ramp samples (0, 100, 200, ...) SHALL each match a bit-exact golden model computed across the wr_ptr wrap.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter: controller state encoding, default
// tap count and the default coefficient set.
//
// FIR_COEF is a 16-tap symmetric low-pass in Q1.15. Element k is the weight
// applied to x[n-k]. The coefficients sum to 31900, which is below 1.0, so a
// full-scale DC input cannot saturate the output.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_e;

    localparam int FIR_TAPS   = 16;
    localparam int FIR_COEF_W = 16;

    // In the concatenation the leftmost item is element [15]. The set is
    // symmetric, so the listing reads the same in either direction.
    localparam logic [FIR_TAPS-1:0][FIR_COEF_W-1:0] FIR_COEF = {
        -16'sd100, -16'sd250, 16'sd0,    16'sd800,
         16'sd2000, 16'sd3400, 16'sd4700, 16'sd5400,
         16'sd5400, 16'sd4700, 16'sd3400, 16'sd2000,
         16'sd800,  16'sd0,   -16'sd250, -16'sd100
    };

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath for the FIR filter.
//
// Ports:
//   clk_i     system clock (rising edge)
//   reset_ni  asynchronous active-low reset; clears the accumulator
//   clear_i   synchronous accumulator clear; takes priority over en_i
//   en_i      adds sample_i * coef_i to the accumulator
//   sample_i  signed sample operand
//   coef_i    signed Q1.(COEF_W-1) coefficient operand
//   acc_o     signed accumulator value
module fir_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = DATA_W + COEF_W + 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     clear_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    assign prod = sample_i * coef_i;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            // Sign-extend the product. The clog2(TAPS) guard bits above the
            // product width keep a full-length sum from overflowing.
            acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_filter.sv
// Sequential single-multiplier FIR filter, one result per accepted sample.
//
// Ports:
//   clk_i           system clock (rising edge)
//   reset_ni        asynchronous active-low reset
//   sample_valid_i  one-cycle strobe: a new sample is on sample_i
//   sample_i        signed input sample
//   clear_i         synchronous flush of the delay line; aborts any computation
//   data_o          filtered sample, held until the next result
//   valid_o         one-cycle pulse while data_o carries a new result
//   busy_o          high whenever the controller is not idle
//   overrun_o       sticky flag: a sample arrived while busy and was dropped
//
// State table:
//   state    | meaning
//   ST_IDLE  | waiting for a sample; writes it into the delay line on arrival
//   ST_MAC   | one tap per cycle, k = 0..TAPS-1, reads x[(wr_ptr-k) mod TAPS]
//   ST_ROUND | round, shift and saturate the accumulator into data_o
//   ST_OUT   | valid_o high; advance wr_ptr
module fir_filter
    import fir_pkg::*;
#(
    parameter int                             TAPS   = FIR_TAPS,
    parameter int                             DATA_W = 16,
    parameter int                             COEF_W = FIR_COEF_W,
    parameter logic [TAPS-1:0][COEF_W-1:0]    COEF   = FIR_COEF
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     sample_valid_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic                     clear_i,
    output logic signed [DATA_W-1:0] data_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam int PTR_W = $clog2(TAPS);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);

    localparam logic [PTR_W-1:0]        LAST    = PTR_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] RND_K   = ACC_W'(64'sd1 <<< (COEF_W - 2));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (DATA_W - 1)));

    fir_state_e               state_q, state_d;
    logic [PTR_W-1:0]         k_q, k_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q;
    logic signed [DATA_W-1:0] line_q [TAPS];
    logic signed [DATA_W-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    logic                     mac_clr;
    logic                     mac_en;
    logic                     wr_en;
    logic                     ptr_adv;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [DATA_W-1:0] data_sat;

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (mac_clr),
        .en_i     (mac_en),
        .sample_i (line_q[rd_ptr_q]),
        .coef_i   ($signed(COEF[k_q])),
        .acc_o    (acc)
    );

    // Round half up, then drop the Q1.(COEF_W-1) fraction bits.
    always_comb begin
        acc_rnd = acc + RND_K;
        acc_shr = acc_rnd >>> (COEF_W - 1);
        if (acc_shr > SAT_MAX) begin
            data_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (acc_shr < SAT_MIN) begin
            data_sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            data_sat = acc_shr[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rd_ptr_d  = rd_ptr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        wr_en     = 1'b0;
        ptr_adv   = 1'b0;

        if (clear_i) begin
            // The flush wins over everything. A sample in the same cycle is
            // dropped silently, and data_o keeps its last value.
            state_d   = ST_IDLE;
            k_d       = '0;
            rd_ptr_d  = '0;
            mac_clr   = 1'b1;
            overrun_d = 1'b0;
        end else begin
            if (sample_valid_i && (state_q != ST_IDLE)) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sample_valid_i) begin
                        wr_en    = 1'b1;
                        mac_clr  = 1'b1;
                        k_d      = '0;
                        rd_ptr_d = wr_ptr_q;
                        state_d  = ST_MAC;
                    end
                end
                ST_MAC: begin
                    mac_en   = 1'b1;
                    // Walk backwards through the circular line, newest sample first.
                    rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - 1'b1;
                    if (k_q == LAST) begin
                        state_d = ST_ROUND;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                ST_ROUND: begin
                    data_d  = data_sat;
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end
                ST_OUT: begin
                    ptr_adv = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            rd_ptr_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            rd_ptr_q  <= rd_ptr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                line_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                line_q[wr_ptr_q] <= sample_i;
            end
            if (ptr_adv) begin
                wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fir_filter.sv
// Testbench for fir_filter: impulse, DC/saturation, latency and overrun,
// clear, circular-pointer wrap, and mid-computation reset.
module tb_fir_filter;
    import fir_pkg::*;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] exp;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_valid = 1'b0;
    logic               clear = 1'b0;
    logic signed [15:0] sample = '0;

    logic signed [15:0] data_o;
    logic               valid_o, busy_o, overrun_o;
    logic signed [15:0] sat_data;
    logic               sat_valid, sat_busy, sat_overrun;

    always #5 clk = ~clk;

    fir_filter dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .sample_valid_i (sample_valid),
        .sample_i       (sample),
        .clear_i        (clear),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o)
    );

    // Taps summing to 2.0 so that a full-scale DC input must saturate.
    fir_filter #(.COEF({16{16'h1000}})) dut_sat (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .sample_valid_i (sample_valid),
        .sample_i       (sample),
        .clear_i        (clear),
        .data_o         (sat_data),
        .valid_o        (sat_valid),
        .busy_o         (sat_busy),
        .overrun_o      (sat_overrun)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int t_drive = 0;

    logic signed [15:0] exp_q[$];
    logic signed [15:0] m_hist[16];
    int                 m_ptr = 0;
    vec_t               imp_tab[17];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 16; i++) m_hist[i] = '0;
        m_ptr = 0;
    endfunction

    // Golden model: wide exact sum, round half up, shift, saturate.
    function automatic logic signed [15:0] model_push(input logic signed [15:0] x);
        longint acc;
        m_hist[m_ptr] = x;
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            acc += longint'($signed(FIR_COEF[k])) * longint'(m_hist[(m_ptr - k + 16) % 16]);
        end
        m_ptr = (m_ptr + 1) % 16;
        acc = (acc + 64'sd16384) >>> 15;
        if (acc > 32767) return 16'sd32767;
        if (acc < -32768) return -16'sd32768;
        return 16'(acc);
    endfunction

    // Scoreboard: every valid_o pulse pops one expected value.
    always @(negedge clk) begin
        if (reset_n && valid_o) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got valid_o=1 with data %0d, expected no output (cycle %0d)",
                         data_o, cyc);
            end else begin
                check("scoreboard_data", longint'(data_o), longint'(exp_q.pop_front()));
            end
        end
    end

    // Called on a falling edge; returns one falling edge later.
    task automatic send(input logic signed [15:0] x, input bit use_tab, input logic signed [15:0] tab_exp);
        logic signed [15:0] e;
        e = model_push(x);
        exp_q.push_back(use_tab ? tab_exp : e);
        sample_valid = 1'b1;
        sample = x;
        t_drive = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_impulse();
        for (int i = 0; i < 17; i++) begin
            send(imp_tab[i].x, 1'b1, imp_tab[i].exp);
            drain();
        end
    endtask

    initial begin
        longint csum;
        longint dc_exp;
        int     nv;

        for (int i = 0; i < 17; i++) begin
            imp_tab[i].x   = (i == 0) ? 16'sd32767 : 16'sd0;
            imp_tab[i].exp = (i < 16) ? $signed(FIR_COEF[i]) : 16'sd0;
        end
        csum = 0;
        for (int k = 0; k < 16; k++) csum += longint'($signed(FIR_COEF[k]));
        dc_exp = (32767 * csum + 16384) >>> 15;

        // Reset state
        m_clear();
        repeat (3) @(negedge clk);
        check("rst_data", longint'(data_o), 0);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overrun", overrun_o, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Impulse response
        run_impulse();

        // DC settle, then saturation both ways on the high-gain instance
        for (int i = 0; i < 20; i++) begin
            send(16'sd32767, 1'b0, '0);
            drain();
        end
        check("dc_settle", longint'(data_o), dc_exp);
        check("sat_pos", longint'(sat_data), 32767);
        for (int i = 0; i < 16; i++) begin
            send(-16'sd32768, 1'b0, '0);
            drain();
        end
        check("sat_neg", longint'(sat_data), -32768);

        // Latency and overrun: second strobe lands in cycle 5 and is dropped
        send(16'sd1000, 1'b0, '0);
        repeat (4) @(negedge clk);
        check("busy_in_mac", busy_o, 1);
        sample_valid = 1'b1;
        sample = -16'sd5000;
        @(negedge clk);
        sample_valid = 1'b0;
        drain();
        check("latency", longint'(last_valid_cyc - t_drive), 18);
        check("overrun_set", overrun_o, 1);

        // Clear coincident with a strobe
        nv = n_valid;
        clear = 1'b1;
        sample_valid = 1'b1;
        sample = 16'sd12345;
        @(negedge clk);
        clear = 1'b0;
        sample_valid = 1'b0;
        m_clear();
        check("clear_overrun", overrun_o, 0);
        repeat (25) @(negedge clk);
        check("clear_no_valid", longint'(n_valid - nv), 0);
        check("clear_idle", busy_o, 0);
        run_impulse();

        // Ramp across the wr_ptr wrap
        for (int i = 0; i < 40; i++) begin
            send(16'(i * 100), 1'b0, '0);
            drain();
        end

        // Reset in the middle of MAC
        send(16'sd7777, 1'b0, '0);
        repeat (7) @(negedge clk);
        check("busy_before_reset", busy_o, 1);
        reset_n = 1'b0;
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_data", longint'(data_o), 0);
        check("reset_valid", valid_o, 0);
        exp_q.delete();
        m_clear();
        nv = n_valid;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("reset_no_valid", longint'(n_valid - nv), 0);
        check("reset_overrun", overrun_o, 0);

        // First sample after reset sees an all-zero history
        send(16'sd20000, 1'b0, '0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
